jam_load_ctrl: RTL and testbench

- Controller that owns the parallel-load (JAM) port of the 4-bit synchronous state sequencer.
- Arbitrates load requests from two requesters, validates each target code against the legal-state set, and sequences JAM_A..D / JAM_Enable with defined setup, pulse and release phases.
- Confirms the sequencer adopted the code.
- Watchdog: monitors sequencer outputs and auto-loads a recovery code if the sequencer stays in an illegal code.
- Sits between host/test logic and the sequencer instance.

---
 rtl/jam_pkg.sv | 21 ++
 rtl/jam_watchdog.sv | 36 +++
 rtl/jam_load_ctrl.sv | 142 ++++++++++++++
 tb/tb_jam_load_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and defaults for the sequencer parallel-load controller.
package jam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_PULSE   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Sequencer code, bit order {D,C,B,A}
  typedef logic [3:0] code_t;

  localparam logic [15:0] DEF_LEGAL_MASK   = 16'h9FFF;
  localparam code_t       DEF_RECOVER_CODE = 4'b0011;

  function automatic logic is_legal(input code_t code, input logic [15:0] mask);
    return mask[code];
  endfunction

endpackage

// File: rtl/jam_watchdog.sv
// Counts consecutive idle cycles spent on an illegal sequencer code and
// raises a one-cycle fire when the limit is reached.
module jam_watchdog #(
  parameter int unsigned WD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic illegal,
  output logic fire
);

  logic [3:0] cnt_q, cnt_d;

  // Fire is combinational so the controller can act in the same idle cycle
  always_comb begin
    fire  = 1'b0;
    cnt_d = '0;
    if (in_idle && illegal) begin
      if (cnt_q == 4'(WD_CYCLES - 1)) begin
        fire = 1'b1;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jam_load_ctrl.sv
// Owns the sequencer JAM port: arbitrates two load requesters, validates
// codes, sequences setup/pulse/release and verifies the adopted state.
module jam_load_ctrl
  import jam_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter logic [15:0] LEGAL_MASK   = DEF_LEGAL_MASK,
  parameter code_t       RECOVER_CODE = DEF_RECOVER_CODE,
  parameter int unsigned WD_CYCLES    = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req_Load,
  input  logic [3:0] Req_Code0,
  input  logic [3:0] Req_Code1,
  output logic [1:0] Grant,
  output logic       Done,
  output logic       Fail,
  input  logic       Qa,
  input  logic       Qb,
  input  logic       Qc,
  input  logic       Qd,
  output logic       JAM_A,
  output logic       JAM_B,
  output logic       JAM_C,
  output logic       JAM_D,
  output logic       JAM_Enable,
  output logic       Busy,
  output logic [7:0] Recover_Count
);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  code_t      target_q, target_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic       match_q, match_d;
  logic [7:0] rcnt_q, rcnt_d;

  logic [1:0] grant;
  logic       done;
  logic       fail;
  logic       gnt_idx;
  code_t      req_code;
  code_t      q_code;
  logic       wd_fire;

  assign q_code = {Qd, Qc, Qb, Qa};

  jam_watchdog #(
    .WD_CYCLES(WD_CYCLES)
  ) u_watchdog (
    .clk    (Clk),
    .rst    (Reset),
    .in_idle(state_q == ST_IDLE),
    .illegal(!is_legal(q_code, LEGAL_MASK)),
    .fire   (wd_fire)
  );

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    target_d = target_q;
    pcnt_d   = pcnt_q;
    match_d  = match_q;
    rcnt_d   = rcnt_q;
    grant    = '0;
    done     = 1'b0;
    fail     = 1'b0;
    gnt_idx  = 1'b0;
    req_code = '0;

    case (state_q)
      ST_IDLE: begin
        if (wd_fire) begin
          target_d = RECOVER_CODE;
          if (rcnt_q != 8'hFF) begin
            rcnt_d = rcnt_q + 8'd1;
          end
          state_d = ST_SETUP;
        end else if (|Req_Load) begin
          gnt_idx  = (Req_Load == 2'b11) ? rr_q : Req_Load[1];
          grant    = gnt_idx ? 2'b10 : 2'b01;
          rr_d     = ~gnt_idx;
          req_code = gnt_idx ? Req_Code1 : Req_Code0;
          // Illegal targets are rejected without touching the JAM data lines
          if (is_legal(req_code, LEGAL_MASK)) begin
            target_d = req_code;
            state_d  = ST_SETUP;
          end else begin
            fail = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        pcnt_d  = '0;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (pcnt_q == 4'(PULSE_CYCLES - 1)) begin
          match_d = (q_code == target_q);
          state_d = ST_RELEASE;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      ST_RELEASE: begin
        done    = match_q;
        fail    = !match_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      target_q <= '0;
      pcnt_q   <= '0;
      match_q  <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      target_q <= target_d;
      pcnt_q   <= pcnt_d;
      match_q  <= match_d;
      rcnt_q   <= rcnt_d;
    end
  end

  // Grant/Fail decode straight from the request inputs, so hold them low in reset
  assign Grant         = Reset ? 2'b00 : grant;
  assign Fail          = Reset ? 1'b0 : fail;
  assign Done          = done;
  assign JAM_Enable    = (state_q == ST_PULSE);
  assign Busy          = (state_q != ST_IDLE);
  assign {JAM_D, JAM_C, JAM_B, JAM_A} = target_q;
  assign Recover_Count = rcnt_q;

endmodule

// File: tb/tb_jam_load_ctrl.sv
// Scoreboard bench for jam_load_ctrl with a simple behavioural sequencer.
module tb_jam_load_ctrl;

  logic       Clk;
  logic       Reset;
  logic [1:0] Req_Load;
  logic [3:0] Req_Code0;
  logic [3:0] Req_Code1;
  logic [1:0] Grant;
  logic       Done;
  logic       Fail;
  logic       JAM_A, JAM_B, JAM_C, JAM_D;
  logic       JAM_Enable;
  logic       Busy;
  logic [7:0] Recover_Count;

  logic [3:0] q = 4'b0000;
  logic       ignore_jam;
  logic       set_q_req;
  logic [3:0] set_q_val;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] grant;
    logic       done;
    logic       fail;
    logic       chk_jam;
    logic [3:0] jam;
  } exp_t;

  exp_t exp_q[$];

  jam_load_ctrl #(
    .PULSE_CYCLES(2),
    .LEGAL_MASK  (16'h9FFF),
    .RECOVER_CODE(4'b0011),
    .WD_CYCLES   (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Req_Load     (Req_Load),
    .Req_Code0    (Req_Code0),
    .Req_Code1    (Req_Code1),
    .Grant        (Grant),
    .Done         (Done),
    .Fail         (Fail),
    .Qa           (q[0]),
    .Qb           (q[1]),
    .Qc           (q[2]),
    .Qd           (q[3]),
    .JAM_A        (JAM_A),
    .JAM_B        (JAM_B),
    .JAM_C        (JAM_C),
    .JAM_D        (JAM_D),
    .JAM_Enable   (JAM_Enable),
    .Busy         (Busy),
    .Recover_Count(Recover_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Sequencer stand-in: adopts the JAM code on a clock edge with JAM_Enable high
  always @(posedge Clk) begin
    if (set_q_req) q <= set_q_val;
    else if (JAM_Enable && !ignore_jam) q <= {JAM_D, JAM_C, JAM_B, JAM_A};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] g, input logic d, input logic f,
                         input logic cj, input logic [3:0] j);
    exp_t e;
    e.grant = g; e.done = d; e.fail = f; e.chk_jam = cj; e.jam = cj ? j : 4'h0;
    exp_q.push_back(e);
  endtask

  // Monitor: every Grant/Done/Fail pulse must match the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && (Grant != 2'b00 || Done || Fail)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 32'({Grant, Done, Fail}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_event",
                32'({Grant, Done, Fail, e.chk_jam ? {JAM_D, JAM_C, JAM_B, JAM_A} : 4'h0}),
                32'({e.grant, e.done, e.fail, e.jam}));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish within 1ms");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_grant(input int idx);
    logic got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Grant[idx]) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("grant_timeout", 32'(got), 32'h1);
  endtask

  task automatic wait_idle();
    logic got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (!Busy) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    check("idle_timeout", 32'(got), 32'h1);
  endtask

  task automatic do_load(input int idx, input logic [3:0] code, input logic legal, input logic ok);
    push_ev((idx == 1) ? 2'b10 : 2'b01, 1'b0, !legal, 1'b0, 4'h0);
    if (legal) push_ev(2'b00, ok, !ok, 1'b1, code);
    if (idx == 1) Req_Code1 = code; else Req_Code0 = code;
    Req_Load[idx] = 1'b1;
    wait_grant(idx);
    cyc();
    Req_Load[idx] = 1'b0;
    wait_idle();
    cyc();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({Grant, Done, Fail, JAM_Enable, Busy, JAM_D, JAM_C, JAM_B, JAM_A, Recover_Count}),
          32'h0);
  endtask

  initial begin
    int ngr;
    Reset      = 1'b1;
    Req_Load   = 2'b00;
    Req_Code0  = 4'h0;
    Req_Code1  = 4'h0;
    ignore_jam = 1'b0;
    set_q_req  = 1'b0;
    set_q_val  = 4'h0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("reset_outputs");
    cyc();
    Reset = 1'b0;
    cyc();

    // Basic load with cycle-accurate enable window
    push_ev(2'b01, 1'b0, 1'b0, 1'b0, 4'h0);
    push_ev(2'b00, 1'b1, 1'b0, 1'b1, 4'b0011);
    Req_Code0 = 4'b0011;
    Req_Load  = 2'b01;
    @(negedge Clk);
    check("t1_c0_en_busy", 32'({JAM_Enable, Busy}), 32'h0);
    cyc();
    Req_Load = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      check("t1_jam_enable", 32'(JAM_Enable), 32'((c == 2 || c == 3) ? 1 : 0));
      if (c == 2) check("t1_jam_data", 32'({JAM_D, JAM_C, JAM_B, JAM_A}), 32'h3);
      if (c == 3) check("t1_q_in_pulse", 32'(q), 32'h3);
      cyc();
    end
    @(negedge Clk);
    check("t1_idle_after", 32'(Busy), 32'h0);
    cyc();

    // Illegal code from requester 1: immediate Fail, no load activity
    do_load(1, 4'b1101, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      check("ill_quiet", 32'({JAM_Enable, Busy, JAM_D, JAM_C, JAM_B, JAM_A}), 32'h3);
      cyc();
    end

    // Both requesters held: strict alternation starting with requester 0
    Req_Code0 = 4'b0110;
    Req_Code1 = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      push_ev((k % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0, 1'b0, 4'h0);
      push_ev(2'b00, 1'b1, 1'b0, 1'b1, (k % 2 == 1) ? 4'b0011 : 4'b0110);
    end
    Req_Load = 2'b11;
    ngr = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge Clk);
      if (Grant != 2'b00) ngr++;
      if (ngr == 4) break;
      cyc();
    end
    check("rr_grant_count", 32'(ngr), 32'd4);
    cyc();
    Req_Load = 2'b00;
    wait_idle();
    cyc();

    // Watchdog: illegal code 1110 for four idle cycles triggers recovery
    set_q_val = 4'b1110;
    set_q_req = 1'b1;
    cyc();
    set_q_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      check("wd_pre_fire", 32'({Busy, Recover_Count}), 32'h0);
      cyc();
    end
    push_ev(2'b00, 1'b1, 1'b0, 1'b1, 4'b0011);
    push_ev(2'b01, 1'b0, 1'b0, 1'b0, 4'h0);
    push_ev(2'b00, 1'b1, 1'b0, 1'b1, 4'b0110);
    Req_Code0 = 4'b0110;
    Req_Load  = 2'b01;
    @(negedge Clk);
    check("wd_fire_no_grant", 32'({Grant, Busy}), 32'h0);
    cyc();
    check("wd_setup", 32'({Busy, Recover_Count, JAM_D, JAM_C, JAM_B, JAM_A}), 32'h1013);
    wait_grant(0);
    cyc();
    Req_Load = 2'b00;
    wait_idle();
    cyc();
    check("wd_count_hold", 32'(Recover_Count), 32'd1);

    // Sequencer ignores the strobe: verify mismatch gives Fail
    ignore_jam = 1'b1;
    do_load(0, 4'b0101, 1'b1, 1'b0);
    ignore_jam = 1'b0;

    // Reset in the middle of PULSE drops the strobe asynchronously
    push_ev(2'b01, 1'b0, 1'b0, 1'b0, 4'h0);
    Req_Code0 = 4'b1000;
    Req_Load  = 2'b01;
    wait_grant(0);
    cyc();
    Req_Load = 2'b00;
    cyc();
    check("rst_pulse_active", 32'(JAM_Enable), 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_async_enable", 32'(JAM_Enable), 32'h0);
    check_all_zero("rst_async_outputs");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cyc();
    do_load(0, 4'b0011, 1'b1, 1'b1);

    repeat (3) cyc();
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
